// File: rtl/snake_motion.sv
// Snake movement engine: paced move steps, body shift/grow, wall and self collision, cell query.
// Optional macro WRAP_EN: the head wraps to the opposite edge instead of hitting a wall.
module snake_motion #(
  parameter int unsigned GRID_W   = 32,
  parameter int unsigned GRID_H   = 24,
  parameter int unsigned X_W      = 5,
  parameter int unsigned Y_W      = 5,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   direction,
  input  logic                         eat,
  input  logic [X_W-1:0]               qx,
  input  logic [Y_W-1:0]               qy,
  output logic                         q_hit,
  output logic [X_W-1:0]               head_x,
  output logic [Y_W-1:0]               head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         step,
  output logic                         game_over
);

  localparam int unsigned L_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0]   X_MAX       = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX       = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_HOME      = X_W'(GRID_W / 2);
  localparam logic [Y_W-1:0]   Y_HOME      = Y_W'(GRID_H / 2);
  localparam logic [L_W-1:0]   LEN_INIT    = L_W'(3);
  localparam logic [L_W-1:0]   LEN_MAX     = L_W'(MAX_LEN);
  localparam logic [2:0]       DIR_DOWN    = 3'b001;
  localparam logic [2:0]       DIR_RESTART = 3'b100;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  function automatic logic [X_W-1:0] home_x(int unsigned i);
    return (i < 3) ? X_HOME : '0;
  endfunction

  function automatic logic [Y_W-1:0] home_y(int unsigned i);
    return (i < 3) ? (Y_HOME - Y_W'(i)) : '0;
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       heading, heading_nx;
  logic             grow_pend, grow_pend_nx;
  logic [L_W-1:0]   len_nx;
  logic [X_W-1:0]   seg_x    [MAX_LEN];
  logic [X_W-1:0]   seg_x_nx [MAX_LEN];
  logic [Y_W-1:0]   seg_y    [MAX_LEN];
  logic [Y_W-1:0]   seg_y_nx [MAX_LEN];
  logic             q_hit_nx, step_nx, game_over_nx;

  logic             restart, move, grow, wall, wall_hit, self_hit, hit_c;
  logic [2:0]       dir_sel;
  logic [X_W-1:0]   nx_x;
  logic [Y_W-1:0]   nx_y;
  logic [L_W-1:0]   chk_len;

  // Heading taken at a move: any direction code except the exact reverse of the current one.
  always_comb begin
    dir_sel = heading;
    if (!direction[2] && ((direction ^ heading) != 3'b010)) begin
      dir_sel = direction;
    end
  end

  // Candidate head cell (already wrapped) and whether it crossed an edge; 00=R 01=D 10=L 11=U.
  always_comb begin
    nx_x = seg_x[0];
    nx_y = seg_y[0];
    wall = 1'b0;
    case (dir_sel[1:0])
      2'b00: begin
        wall = (seg_x[0] == X_MAX);
        nx_x = wall ? '0 : seg_x[0] + X_W'(1);
      end
      2'b01: begin
        wall = (seg_y[0] == Y_MAX);
        nx_y = wall ? '0 : seg_y[0] + Y_W'(1);
      end
      2'b10: begin
        wall = (seg_x[0] == '0);
        nx_x = wall ? X_MAX : seg_x[0] - X_W'(1);
      end
      default: begin
        wall = (seg_y[0] == '0);
        nx_y = wall ? Y_MAX : seg_y[0] - Y_W'(1);
      end
    endcase
  end

`ifdef WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = wall;
`endif

  // Self collision ignores the tail unless it stays put (growing); query scans live segments.
  always_comb begin
    grow     = grow_pend | eat;
    chk_len  = grow ? length : length - L_W'(1);
    self_hit = 1'b0;
    hit_c    = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((L_W'(i) < chk_len) && (seg_x[i] == nx_x) && (seg_y[i] == nx_y)) begin
        self_hit = 1'b1;
      end
      if ((L_W'(i) < length) && (seg_x[i] == qx) && (seg_y[i] == qy)) begin
        hit_c = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    heading_nx   = heading;
    grow_pend_nx = grow_pend;
    len_nx       = length;
    seg_x_nx     = seg_x;
    seg_y_nx     = seg_y;
    step_nx      = 1'b0;
    q_hit_nx     = hit_c;
    restart      = (direction == DIR_RESTART);
    move         = 1'b0;

    case (state)
      S_INIT: state_nx = S_RUN;
      S_RUN: begin
        move   = (cnt == CNT_LAST);
        cnt_nx = move ? '0 : cnt + CNT_W'(1);
        if (eat) begin
          grow_pend_nx = 1'b1;
        end
        if (move) begin
          heading_nx = dir_sel;
          if (wall_hit || self_hit) begin
            state_nx = S_OVER;
          end else begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
              seg_x_nx[i] = seg_x[i-1];
              seg_y_nx[i] = seg_y[i-1];
            end
            seg_x_nx[0] = nx_x;
            seg_y_nx[0] = nx_y;
            if (grow && (length != LEN_MAX)) begin
              len_nx = length + L_W'(1);
            end
            grow_pend_nx = 1'b0;
            step_nx      = 1'b1;
          end
        end
      end
      S_OVER: ;
      default: state_nx = S_INIT;
    endcase

    // Restart wins over any move in the same cycle and re-creates the reset picture.
    if (restart) begin
      state_nx     = S_INIT;
      cnt_nx       = '0;
      heading_nx   = DIR_DOWN;
      grow_pend_nx = 1'b0;
      len_nx       = LEN_INIT;
      step_nx      = 1'b0;
      q_hit_nx     = 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_nx[i] = home_x(i);
        seg_y_nx[i] = home_y(i);
      end
    end

    game_over_nx = (state_nx == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      heading   <= DIR_DOWN;
      grow_pend <= 1'b0;
      length    <= LEN_INIT;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= home_x(i);
        seg_y[i] <= home_y(i);
      end
      q_hit     <= 1'b0;
      step      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      heading   <= heading_nx;
      grow_pend <= grow_pend_nx;
      length    <= len_nx;
      seg_x     <= seg_x_nx;
      seg_y     <= seg_y_nx;
      q_hit     <= q_hit_nx;
      step      <= step_nx;
      game_over <= game_over_nx;
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

endmodule

// File: tb/tb_snake_motion.sv
// Bench for snake_motion: directed scenarios with literal expectations, then random play
// against a queue-based snake model compared every cycle.
`timescale 1ns/1ps
module tb_snake_motion;

  localparam int GRID_W   = 32;
  localparam int GRID_H   = 24;
  localparam int X_W      = 5;
  localparam int Y_W      = 5;
  localparam int MAX_LEN  = 16;
  localparam int TICK_DIV = 4;
  localparam int L_W      = $clog2(MAX_LEN + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [2:0]     direction = 3'b001;
  logic           eat = 1'b0;
  logic [X_W-1:0] qx = '0;
  logic [Y_W-1:0] qy = '0;
  logic           q_hit, step, game_over;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic [L_W-1:0] length;

  snake_motion #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W),
    .MAX_LEN(MAX_LEN), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .direction(direction), .eat(eat), .qx(qx), .qy(qy),
    .q_hit(q_hit), .head_x(head_x), .head_y(head_y), .length(length),
    .step(step), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model: body as a queue of cells, head first; mode 0=idle 1=playing 2=dead.
  int bx[$];
  int by[$];
  int m_mode, m_cnt, m_head, m_pend, m_step, m_hit;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int dx_of(input int d);
    case (d)
      0:       return 1;
      2:       return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dy_of(input int d);
    case (d)
      1:       return 1;
      3:       return -1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    bx.delete();
    by.delete();
    for (int i = 0; i < 3; i++) begin
      bx.push_back(GRID_W / 2);
      by.push_back(GRID_H / 2 - i);
    end
    m_mode = 0; m_cnt = 0; m_head = 1; m_pend = 0; m_step = 0; m_hit = 0;
  endtask

  task automatic model_move(input int dir);
    int nx, ny, lim;
    bit grow, dead;
    if (dir < 4 && !((dx_of(dir) + dx_of(m_head) == 0) && (dy_of(dir) + dy_of(m_head) == 0)))
      m_head = dir;
    nx = bx[0] + dx_of(m_head);
    ny = by[0] + dy_of(m_head);
`ifdef WRAP_EN
    nx = (nx + GRID_W) % GRID_W;
    ny = (ny + GRID_H) % GRID_H;
    dead = 1'b0;
`else
    dead = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
`endif
    grow = (m_pend != 0) || eat;
    lim  = grow ? bx.size() : bx.size() - 1;
    for (int i = 0; i < lim; i++)
      if (bx[i] == nx && by[i] == ny) dead = 1'b1;
    if (dead) begin
      m_mode = 2;
    end else begin
      bx.push_front(nx);
      by.push_front(ny);
      if (!grow) begin
        void'(bx.pop_back());
        void'(by.pop_back());
      end
      if (bx.size() > MAX_LEN) begin
        void'(bx.pop_back());
        void'(by.pop_back());
      end
      m_pend = 0;
      m_step = 1;
    end
  endtask

  // Advance the model by one clock edge using the inputs that edge saw.
  task automatic model_step();
    bit hit;
    m_step = 0;
    if (rst || direction == 3'b100) begin
      model_reset();
      return;
    end
    hit = 1'b0;
    for (int i = 0; i < bx.size(); i++)
      if (bx[i] == int'(qx) && by[i] == int'(qy)) hit = 1'b1;
    m_hit = hit;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (eat) m_pend = 1;
      if (m_cnt == TICK_DIV - 1) begin
        m_cnt = 0;
        model_move(int'(direction));
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    model_step();
  endtask

  task automatic move_dir(input logic [2:0] d);
    direction = d;
    repeat (TICK_DIV) tick();
  endtask

  task automatic grow_move();
    eat = 1'b1;
    tick();
    eat = 1'b0;
    repeat (TICK_DIV - 1) tick();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("head_x",    int'(head_x),    bx[0]);
      check("head_y",    int'(head_y),    by[0]);
      check("length",    int'(length),    bx.size());
      check("step",      int'(step),      m_step);
      check("game_over", int'(game_over), int'(m_mode == 2));
      check("q_hit",     int'(q_hit),     m_hit);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int k;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_head_x", int'(head_x), 16);
    check("rst_head_y", int'(head_y), 12);
    check("rst_length", int'(length), 3);
    check("rst_step",   int'(step), 0);
    check("rst_over",   int'(game_over), 0);
    check("rst_q_hit",  int'(q_hit), 0);
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Paced steps going down.
    repeat (5) tick();
    check("t1_step1",  int'(step), 1);
    check("t1_head_y", int'(head_y), 13);
    check("t1_head_x", int'(head_x), 16);
    tick();
    check("t1_step_gap", int'(step), 0);
    repeat (TICK_DIV - 1) tick();
    check("t1_step2",   int'(step), 1);
    check("t1_head_y2", int'(head_y), 14);
    check("t1_length",  int'(length), 3);

    // Reversal rejected, then turn right.
    move_dir(3'b011);
    check("t2_rev_y", int'(head_y), 15);
    check("t2_rev_x", int'(head_x), 16);
    move_dir(3'b000);
    check("t2_turn_x", int'(head_x), 17);
    check("t2_turn_y", int'(head_y), 15);

    // Grow keeps the old tail cell (16,14) occupied.
    qx = 5'd16;
    qy = 5'd14;
    grow_move();
    check("t3_length", int'(length), 4);
    check("t3_head_x", int'(head_x), 18);
    tick();
    check("t3_q_hit", int'(q_hit), 1);

    // Run into the right edge.
    for (int i = 0; i < 200 && bx[0] != GRID_W - 1; i++) tick();
    check("t4_at_edge", int'(head_x), 31);
    repeat (TICK_DIV) tick();
`ifdef WRAP_EN
    check("t4_wrap_x",    int'(head_x), 0);
    check("t4_wrap_over", int'(game_over), 0);
`else
    check("t4_wall_over", int'(game_over), 1);
    check("t4_wall_x",    int'(head_x), 31);
    check("t4_wall_step", int'(step), 0);
    repeat (8) tick();
    check("t4_frozen_x",  int'(head_x), 31);
`endif
    check("t4_length", int'(length), 4);

    // Restart, grow to 5, then loop into own body.
    direction = 3'b100;
    tick();
    check("t5_rs_over", int'(game_over), 0);
    check("t5_rs_x",    int'(head_x), 16);
    check("t5_rs_y",    int'(head_y), 12);
    check("t5_rs_len",  int'(length), 3);
    qx = '0;
    qy = '0;
    direction = 3'b001;
    tick();
    grow_move();
    check("t5_len4", int'(length), 4);
    grow_move();
    check("t5_len5",  int'(length), 5);
    check("t5_len5_y", int'(head_y), 14);
    move_dir(3'b000);
    move_dir(3'b001);
    move_dir(3'b010);
    check("t5_pre_x", int'(head_x), 16);
    check("t5_pre_y", int'(head_y), 15);
    move_dir(3'b011);
    check("t5_self_over", int'(game_over), 1);
    check("t5_self_step", int'(step), 0);
    check("t5_self_y",    int'(head_y), 15);
    direction = 3'b100;
    tick();
    check("t5_re_over", int'(game_over), 0);
    check("t5_re_y",    int'(head_y), 12);
    check("t5_re_len",  int'(length), 3);

    // Reset asserted just before a move would fire.
    direction = 3'b001;
    tick();
    repeat (TICK_DIV) tick();
    check("t6_moved_y", int'(head_y), 13);
    repeat (TICK_DIV - 1) tick();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_y",    int'(head_y), 12);
    check("t6_async_len",  int'(length), 3);
    check("t6_async_step", int'(step), 0);
    tick();
    check("t6_no_step", int'(step), 0);
    check("t6_hold_y",  int'(head_y), 12);
    rst = 1'b0;

    // Random play.
    for (int c = 0; c < 16000; c++) begin
      tick();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 2999) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      if (m_mode == 2 && $urandom_range(0, 7) == 0) direction = 3'b100;
      else if ($urandom_range(0, 499) == 0) direction = 3'b100;
      else if ($urandom_range(0, 9) == 0) direction = 3'($urandom_range(0, 3));
      else if (direction == 3'b100) direction = 3'($urandom_range(0, 3));
      eat = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        k  = $urandom_range(0, bx.size() - 1);
        qx = X_W'(bx[k]);
        qy = Y_W'(by[k]);
      end else begin
        qx = X_W'($urandom_range(0, GRID_W - 1));
        qy = Y_W'($urandom_range(0, GRID_H - 1));
      end
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
